// File: rtl/stream_demux.sv
// Packet-locked 1-to-N stream demultiplexer. The first beat of each packet
// picks a destination channel; packets aimed at a missing channel are dropped.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] m_valid,
  input  logic [N_OUT-1:0] m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [7:0]       drop_count,
  output logic [1:0]       state_dbg
);

  // Handshake: a beat moves on either side only in a cycle where valid and
  // ready are both high; valid never waits on ready, and once raised the
  // output beat (m_valid/m_data/m_last) is held unchanged until accepted.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             ov;
  logic [WIDTH-1:0] odata;
  logic             olast;
  logic [SEL_W-1:0] odest;
  logic [SEL_W-1:0] dest_q, dest_nxt;
  logic [SEL_W-1:0] load_dest;

  logic out_ready;
  logic accept;
  logic sel_ok;
  logic load;
  logic drop_first;

  // Per-channel valid decode of the single output register.
  for (genvar g = 0; g < N_OUT; g++) begin : g_valid
    assign m_valid[g] = ov && (odest == SEL_W'(g));
  end

  // With ov set, exactly the addressed channel is in m_valid, so this is
  // m_ready[odest] without indexing past N_OUT when SEL_W is wider.
  assign out_ready = |(m_valid & m_ready);

  assign sel_ok    = ($unsigned(32'(sel)) < $unsigned(N_OUT));
  assign s_ready   = (state == DROP) || !ov || out_ready;
  assign accept    = s_valid && s_ready;
  assign m_data    = odata;
  assign m_last    = olast;
  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    dest_nxt   = dest_q;
    load       = 1'b0;
    load_dest  = dest_q;
    drop_first = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_ok) begin
            load      = 1'b1;
            load_dest = sel;
            dest_nxt  = sel;
            if (!s_last) state_nxt = ROUTE;
          end else begin
            drop_first = 1'b1;
            if (!s_last) state_nxt = DROP;
          end
        end
      end
      ROUTE: begin
        if (accept) begin
          load = 1'b1;
          if (s_last) state_nxt = IDLE;
        end
      end
      DROP: begin
        if (accept && s_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dest_q <= '0;
    end else begin
      state  <= state_nxt;
      dest_q <= dest_nxt;
    end
  end

  // Output register: a reload in the same cycle as completion keeps ov high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov    <= 1'b0;
      odata <= '0;
      olast <= 1'b0;
      odest <= '0;
    end else if (load) begin
      ov    <= 1'b1;
      odata <= s_data;
      olast <= s_last;
      odest <= load_dest;
    end else if (ov && out_ready) begin
      ov <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop_first && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule
